ballot_box: RTL and testbench
=============================

BALLOT_BOX -- requirements
Module: ballot_box

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: open  input  1  start-session pulse.
REQ-004 SHALL have port: close  input  1  end-session pulse.
REQ-005 SHALL have port: bal_valid  input  1  ballot present.
REQ-006 SHALL have port: bal_ready  output  1  ballot can be accepted.
REQ-007 SHALL have port: bal_class  input  2  0=common, 1=vip, 2=vvip, 3=illegal.
REQ-008 SHALL have port: bal_id  input  5  voter index within class.
REQ-009 SHALL have port: bal_yes  input  1  1=yes, 0=no.
REQ-010 SHALL have port: common  output  32  yes-vector, common voters.
REQ-011 SHALL have port: vip  output  8  yes-vector, vip voters.
REQ-012 SHALL have port: vvip  output  1  yes-bit, vvip voter.
REQ-013 SHALL have port: tally  output  7  weighted yes count (0..96).
REQ-014 SHALL have port: result_valid  output  1  decision available.
REQ-015 SHALL have port: result  output  1  1 = motion passes.
REQ-016 SHALL have port: bal_err  output  1  one-cycle pulse, rejected ballot.

Function
REQ-017 SHALL implement FSM states IDLE, COLLECT, DECIDE, DONE.
REQ-018 SHALL transition as follows:
- IDLE->COLLECT on open.
- COLLECT->DECIDE on close.
- DECIDE->DONE unconditionally after 1 cycle.
- DONE->COLLECT on open.
REQ-019 SHALL ignore open while in COLLECT or DECIDE, and ignore close outside COLLECT.
REQ-020 SHALL clear common, vip, vvip, tally, result, result_valid and all voted flags on the clock edge that enters COLLECT.
REQ-021 SHALL drive bal_ready=1 only in COLLECT; a ballot is accepted when bal_valid && bal_ready at a rising edge.
REQ-022 SHALL reject an accepted ballot with no state change and bal_err=1 on the next cycle if any of the following hold:
- class is 3;
- class is vip and id>7;
- class is vvip and id!=0;
- the voter's voted flag is already set.
REQ-023 SHALL, for a legal ballot:
- set the voted flag for (class, id);
- if bal_yes, set the matching bit of common/vip/vvip and add weight 1/4/32 to tally in the same edge.
REQ-024 SHALL keep a legal "no" ballot out of tally while still setting its voted flag, so a later ballot from that voter is a duplicate.
REQ-025 SHALL make tally a 7-bit unsigned value that never wraps; maximum is 32+8*4+32=96.
REQ-026 SHALL, in DECIDE, register result = (tally >= 32), so that result_valid=1 and result are stable from the cycle of entry to DONE.
REQ-027 SHALL hold result_valid, result, tally and the vectors constant in DONE until the next open.
REQ-028 SHALL, when close and an accepted ballot coincide on the same edge, count the ballot before entering DECIDE.
REQ-029 SHALL make result visible exactly 2 rising edges after the close is sampled.
REQ-030 SHALL register all outputs; bal_ready SHALL be a decode of the state register only.

Reset
REQ-031 SHALL, on reset_n=0 and independent of clk:
- force state IDLE;
- force common=0, vip=0, vvip=0, tally=0, result=0, result_valid=0, bal_err=0, bal_ready=0;
- clear all voted flags.
REQ-032 SHALL discard a session in progress on reset mid-COLLECT; the next session starts clean on open.
REQ-033 SHALL remain in IDLE after reset release until open is sampled high.

Verification
REQ-034 Bench SHALL cover threshold pass:
- stimulus: open; 8 vip yes ballots (ids 0-7); close.
- required response: tally=32, result_valid=1 two edges after close, result=1.
REQ-035 Bench SHALL cover below-threshold fail:
- stimulus: open; 31 common yes ballots (ids 0-30); close.
- required response: tally=31, common=32'h7FFFFFFF, result=0.
REQ-036 Bench SHALL cover duplicate and illegal ballots:
- stimulus: common id 5 yes, then common id 5 yes; vip id 9; vvip id 1.
- required response: three bal_err pulses, tally=1, common=32'h00000020.
REQ-037 Bench SHALL cover no-vote lockout:
- stimulus: vvip id 0 no, then vvip id 0 yes.
- required response: second ballot raises bal_err; vvip=0, tally=0.
REQ-038 Bench SHALL cover a ballot coincident with close:
- stimulus: vvip id 0 yes accepted on the same edge as close.
- required response: tally=32, result=1.
REQ-039 Bench SHALL cover reset mid-session and reopen:
- stimulus: assert reset_n low mid-COLLECT with tally=12 and between clock edges; release; open.
- required response: immediately on assertion, outputs zero and state IDLE; after open, tally=0 and bal_ready=1.

Source files
------------

// File: rtl/ballot_box.sv
// Weighted ballot collector: common/vip/vvip voters cast one ballot each per session,
// and the motion passes when the weighted yes count reaches 32.
module ballot_box (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        open,
  input  logic        close,
  input  logic        bal_valid,
  output logic        bal_ready,
  input  logic [1:0]  bal_class,
  input  logic [4:0]  bal_id,
  input  logic        bal_yes,
  output logic [31:0] common,
  output logic [7:0]  vip,
  output logic        vvip,
  output logic [6:0]  tally,
  output logic        result_valid,
  output logic        result,
  output logic        bal_err
);

  typedef enum logic [1:0] {StIdle, StCollect, StDecide, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] common_q, common_d;
  logic [7:0]  vip_q, vip_d;
  logic        vvip_q, vvip_d;
  logic [6:0]  tally_q, tally_d;
  logic        result_q, result_d;
  logic        result_valid_q, result_valid_d;
  logic        bal_err_q, bal_err_d;
  logic [31:0] voted_common_q, voted_common_d;
  logic [7:0]  voted_vip_q, voted_vip_d;
  logic        voted_vvip_q, voted_vvip_d;

  logic enter_collect;
  logic accept;
  logic dup;
  logic illegal;

  assign enter_collect = open && (state_q == StIdle || state_q == StDone);
  assign accept        = bal_valid && (state_q == StCollect);

  always_comb begin
    dup = 1'b1;
    case (bal_class)
      2'd0:    dup = voted_common_q[bal_id];
      2'd1:    dup = voted_vip_q[bal_id[2:0]];
      2'd2:    dup = voted_vvip_q;
      default: dup = 1'b1;
    endcase
  end

  assign illegal = (bal_class == 2'd3) ||
                   (bal_class == 2'd1 && bal_id > 5'd7) ||
                   (bal_class == 2'd2 && bal_id != 5'd0) ||
                   dup;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (open)  state_d = StCollect;
      StCollect: if (close) state_d = StDecide;
      StDecide:             state_d = StDone;
      StDone:    if (open)  state_d = StCollect;
      default:              state_d = StIdle;
    endcase
  end

  always_comb begin
    common_d       = common_q;
    vip_d          = vip_q;
    vvip_d         = vvip_q;
    tally_d        = tally_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    bal_err_d      = 1'b0;
    voted_common_d = voted_common_q;
    voted_vip_d    = voted_vip_q;
    voted_vvip_d   = voted_vvip_q;

    if (enter_collect) begin
      common_d       = '0;
      vip_d          = '0;
      vvip_d         = 1'b0;
      tally_d        = '0;
      result_d       = 1'b0;
      result_valid_d = 1'b0;
      voted_common_d = '0;
      voted_vip_d    = '0;
      voted_vvip_d   = 1'b0;
    end else if (accept) begin
      if (illegal) begin
        bal_err_d = 1'b1;
      end else begin
        // Duplicate lockout makes 96 the ceiling, so the add cannot wrap.
        case (bal_class)
          2'd0: begin
            voted_common_d[bal_id] = 1'b1;
            if (bal_yes) begin
              common_d[bal_id] = 1'b1;
              tally_d          = tally_q + 7'd1;
            end
          end
          2'd1: begin
            voted_vip_d[bal_id[2:0]] = 1'b1;
            if (bal_yes) begin
              vip_d[bal_id[2:0]] = 1'b1;
              tally_d            = tally_q + 7'd4;
            end
          end
          default: begin
            voted_vvip_d = 1'b1;
            if (bal_yes) begin
              vvip_d  = 1'b1;
              tally_d = tally_q + 7'd32;
            end
          end
        endcase
      end
    end else if (state_q == StDecide) begin
      result_d       = (tally_q >= 7'd32);
      result_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      common_q       <= '0;
      vip_q          <= '0;
      vvip_q         <= 1'b0;
      tally_q        <= '0;
      result_q       <= 1'b0;
      result_valid_q <= 1'b0;
      bal_err_q      <= 1'b0;
      voted_common_q <= '0;
      voted_vip_q    <= '0;
      voted_vvip_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      common_q       <= common_d;
      vip_q          <= vip_d;
      vvip_q         <= vvip_d;
      tally_q        <= tally_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      bal_err_q      <= bal_err_d;
      voted_common_q <= voted_common_d;
      voted_vip_q    <= voted_vip_d;
      voted_vvip_q   <= voted_vvip_d;
    end
  end

  assign bal_ready    = (state_q == StCollect);
  assign common       = common_q;
  assign vip          = vip_q;
  assign vvip         = vvip_q;
  assign tally        = tally_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign bal_err      = bal_err_q;

endmodule

// File: tb/tb_ballot_box.sv
// Directed and randomized checks of ballot_box against a set-based voter model.
module tb_ballot_box;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        open, close, bal_valid, bal_ready;
  logic [1:0]  bal_class;
  logic [4:0]  bal_id;
  logic        bal_yes;
  logic [31:0] common;
  logic [7:0]  vip;
  logic        vvip;
  logic [6:0]  tally;
  logic        result_valid, result, bal_err;

  int n_asserts = 0;
  int n_fail    = 0;

  // Model: who voted, and who voted yes, per class.
  bit [31:0] m_yes_c, m_voted_c;
  bit [7:0]  m_yes_v, m_voted_v;
  bit        m_yes_vv, m_voted_vv;

  ballot_box dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .open         (open),
    .close        (close),
    .bal_valid    (bal_valid),
    .bal_ready    (bal_ready),
    .bal_class    (bal_class),
    .bal_id       (bal_id),
    .bal_yes      (bal_yes),
    .common       (common),
    .vip          (vip),
    .vvip         (vvip),
    .tally        (tally),
    .result_valid (result_valid),
    .result       (result),
    .bal_err      (bal_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_tally();
    return $countones(m_yes_c) + 4 * $countones(m_yes_v) + 32 * int'(m_yes_vv);
  endfunction

  function automatic bit m_reject(input int cls, input int id);
    if (cls == 0) return m_voted_c[id];
    if (cls == 1) return (id > 7) || m_voted_v[id[2:0]];
    if (cls == 2) return (id != 0) || m_voted_vv;
    return 1'b1;
  endfunction

  task automatic m_record(input int cls, input int id, input bit yes);
    if (cls == 0) begin m_voted_c[id] = 1'b1; if (yes) m_yes_c[id] = 1'b1; end
    if (cls == 1) begin m_voted_v[id[2:0]] = 1'b1; if (yes) m_yes_v[id[2:0]] = 1'b1; end
    if (cls == 2) begin m_voted_vv = 1'b1; if (yes) m_yes_vv = 1'b1; end
  endtask

  task automatic m_clear();
    m_yes_c = '0; m_voted_c = '0;
    m_yes_v = '0; m_voted_v = '0;
    m_yes_vv = 1'b0; m_voted_vv = 1'b0;
  endtask

  task automatic check_vectors(input string tag);
    chk({tag, ".tally"}, 32'(tally), 32'(m_tally()));
    chk({tag, ".common"}, common, m_yes_c);
    chk({tag, ".vip"}, 32'(vip), 32'(m_yes_v));
    chk({tag, ".vvip"}, 32'(vvip), 32'(m_yes_vv));
  endtask

  task automatic do_open(input string tag);
    open = 1'b1;
    tick();
    open = 1'b0;
    m_clear();
    chk({tag, ".ready"}, 32'(bal_ready), 32'd1);
    chk({tag, ".rvalid"}, 32'(result_valid), 32'd0);
    check_vectors(tag);
  endtask

  task automatic ballot(input string tag, input int cls, input int id, input bit yes,
                        output bit err_seen);
    bit exp_err;
    exp_err   = m_reject(cls, id);
    bal_valid = 1'b1;
    bal_class = cls[1:0];
    bal_id    = id[4:0];
    bal_yes   = yes;
    tick();
    bal_valid = 1'b0;
    chk({tag, ".err"}, 32'(bal_err), 32'(exp_err));
    err_seen = bal_err;
    if (!exp_err) m_record(cls, id, yes);
    check_vectors(tag);
  endtask

  task automatic do_close(input string tag);
    close = 1'b1;
    tick();
    close = 1'b0;
    chk({tag, ".decide_rvalid"}, 32'(result_valid), 32'd0);
    chk({tag, ".decide_ready"}, 32'(bal_ready), 32'd0);
    tick();
    chk({tag, ".rvalid"}, 32'(result_valid), 32'd1);
    chk({tag, ".result"}, 32'(result), 32'(m_tally() >= 32));
    check_vectors(tag);
  endtask

  initial begin
    bit e;
    int errs;
    int cls, id;
    bit yes;

    reset_n = 1'b0; open = 1'b0; close = 1'b0; bal_valid = 1'b0;
    bal_class = '0; bal_id = '0; bal_yes = 1'b0;
    m_clear();
    tick(); tick();
    chk("rst.ready", 32'(bal_ready), 32'd0);
    chk("rst.rvalid", 32'(result_valid), 32'd0);
    chk("rst.result", 32'(result), 32'd0);
    chk("rst.err", 32'(bal_err), 32'd0);
    check_vectors("rst");
    reset_n = 1'b1;
    tick(); tick(); tick();
    chk("idle.ready", 32'(bal_ready), 32'd0);
    // Ballot in IDLE must not be taken.
    bal_valid = 1'b1; bal_class = 2'd2; bal_id = 5'd0; bal_yes = 1'b1;
    tick();
    bal_valid = 1'b0;
    chk("idle.err", 32'(bal_err), 32'd0);
    check_vectors("idle");

    // Threshold pass: eight vip yes ballots reach exactly 32.
    do_open("pass");
    for (int i = 0; i < 8; i++) ballot("pass", 1, i, 1'b1, e);
    do_close("pass");
    chk("pass.tally32", 32'(tally), 32'd32);
    chk("pass.result1", 32'(result), 32'd1);
    tick(); tick();
    chk("done.hold_rvalid", 32'(result_valid), 32'd1);
    chk("done.hold_result", 32'(result), 32'd1);
    close = 1'b1; bal_valid = 1'b1; bal_class = 2'd0; bal_id = 5'd3; bal_yes = 1'b1;
    tick();
    close = 1'b0; bal_valid = 1'b0;
    chk("done.ready", 32'(bal_ready), 32'd0);
    chk("done.err", 32'(bal_err), 32'd0);
    chk("done.rvalid_after_close", 32'(result_valid), 32'd1);
    check_vectors("done");

    // Below threshold: 31 common yes ballots.
    do_open("below");
    for (int i = 0; i < 31; i++) ballot("below", 0, i, 1'b1, e);
    do_close("below");
    chk("below.tally31", 32'(tally), 32'd31);
    chk("below.common", common, 32'h7FFF_FFFF);
    chk("below.result0", 32'(result), 32'd0);

    // Duplicate and illegal ballots.
    do_open("dup");
    errs = 0;
    ballot("dup", 0, 5, 1'b1, e); errs += int'(e);
    ballot("dup", 0, 5, 1'b1, e); errs += int'(e);
    ballot("dup", 1, 9, 1'b1, e); errs += int'(e);
    ballot("dup", 2, 1, 1'b1, e); errs += int'(e);
    tick();
    chk("dup.err_clear", 32'(bal_err), 32'd0);
    chk("dup.errs", 32'(errs), 32'd3);
    chk("dup.tally1", 32'(tally), 32'd1);
    chk("dup.common", common, 32'h0000_0020);
    do_close("dup");

    // A "no" vote still locks the voter out.
    do_open("lock");
    ballot("lock", 2, 0, 1'b0, e);
    chk("lock.first_err", 32'(e), 32'd0);
    ballot("lock", 2, 0, 1'b1, e);
    chk("lock.second_err", 32'(e), 32'd1);
    chk("lock.vvip", 32'(vvip), 32'd0);
    chk("lock.tally", 32'(tally), 32'd0);
    do_close("lock");

    // Ballot on the same edge as close is counted.
    do_open("coin");
    close = 1'b1; bal_valid = 1'b1; bal_class = 2'd2; bal_id = 5'd0; bal_yes = 1'b1;
    tick();
    close = 1'b0; bal_valid = 1'b0;
    m_record(2, 0, 1'b1);
    chk("coin.err", 32'(bal_err), 32'd0);
    chk("coin.decide_rvalid", 32'(result_valid), 32'd0);
    tick();
    chk("coin.rvalid", 32'(result_valid), 32'd1);
    chk("coin.tally", 32'(tally), 32'd32);
    chk("coin.result", 32'(result), 32'd1);

    // Randomized sessions.
    for (int s = 0; s < 6; s++) begin
      do_open("rnd_open");
      for (int k = 0; k < 40; k++) begin
        cls = $urandom_range(0, 3);
        id  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 8);
        yes = 1'($urandom_range(0, 1));
        ballot("rnd", cls, id, yes, e);
        if ($urandom_range(0, 4) == 0) begin
          tick();
          chk("rnd.gap_err", 32'(bal_err), 32'd0);
        end
        if (k == 20) begin
          open = 1'b1;
          tick();
          open = 1'b0;
          chk("rnd.open_ignored", 32'(bal_ready), 32'd1);
          check_vectors("rnd.open_ignored");
        end
      end
      do_close("rnd_close");
    end

    // Asynchronous reset mid-session, then a clean reopen.
    do_open("mid");
    for (int i = 0; i < 12; i++) ballot("mid", 0, i, 1'b1, e);
    chk("mid.tally12", 32'(tally), 32'd12);
    #2;
    reset_n = 1'b0;
    #1;
    m_clear();
    chk("mid.rst_ready", 32'(bal_ready), 32'd0);
    chk("mid.rst_rvalid", 32'(result_valid), 32'd0);
    chk("mid.rst_result", 32'(result), 32'd0);
    chk("mid.rst_err", 32'(bal_err), 32'd0);
    check_vectors("mid.rst");
    #2;
    reset_n = 1'b1;
    tick(); tick();
    chk("mid.idle_ready", 32'(bal_ready), 32'd0);
    do_open("reopen");
    chk("reopen.tally0", 32'(tally), 32'd0);
    ballot("reopen", 0, 0, 1'b1, e);
    chk("reopen.fresh_vote", 32'(e), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
